// File: rtl/pooling_row_sender_pkg.sv
// Shared types and sizing for the pooling-layer row sender.
// DATA_WIDTH falls back to 8 when the global define file has not set it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package pooling_pkg;

   localparam int DATA_WIDTH    = `DATA_WIDTH;
   localparam int INPUT_SIZE    = 6;
   localparam int KERNEL_SIZE   = 2;
   localparam int OUTPUT_SIZE   = INPUT_SIZE / KERNEL_SIZE;
   localparam int TOTAL_FEATURE = 4;
   localparam int FEATURE_WIDTH = 2;
   localparam int ROW_WIDTH     = 3;

   localparam int ROW_BITS   = INPUT_SIZE * DATA_WIDTH;
   localparam int FRAME_ROWS = TOTAL_FEATURE * INPUT_SIZE;
   localparam int CNT_WIDTH  = $clog2(FRAME_ROWS + 1);
   localparam int BEAT_WIDTH = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   typedef struct packed {
      logic [FEATURE_WIDTH-1:0] feature;
      logic [ROW_WIDTH-1:0]     row;
      logic [ROW_BITS-1:0]      data;
   } row_tag_t;

   // Word 0 sits in the MSBs, so a left shift brings window k into the top words.
   function automatic logic [ROW_BITS-1:0] window_shift(input logic [ROW_BITS-1:0] row,
                                                        input logic [BEAT_WIDTH-1:0] beat);
      window_shift = row << (int'(beat) * KERNEL_SIZE * DATA_WIDTH);
   endfunction

endpackage

// File: rtl/pooling_row_sender_if.sv
// Row handshake from the conv buffer plus the beat bus to the pooling layer.
// A row transfers on a rising edge with in_valid && in_ready; beats carry no back-pressure.
interface pooling_row_sender_if;
   import pooling_pkg::*;

   logic                     start;
   logic                     in_valid;
   logic                     in_ready;
   logic [ROW_BITS-1:0]      in_data;
   logic                     output_valid;
   logic [FEATURE_WIDTH-1:0] feature_idx;
   logic [ROW_WIDTH-1:0]     feature_row;
   logic [ROW_BITS-1:0]      data_out;
   logic                     busy;
   logic                     frame_done;
   state_e                   dbg_state;
`ifdef POOL_SENDER_CHECK_EN
   logic                     err;
`endif

   modport master (
      output start, output in_valid, output in_data,
      input in_ready, input output_valid, input feature_idx, input feature_row,
      input data_out, input busy, input frame_done, input dbg_state
`ifdef POOL_SENDER_CHECK_EN
      , input err
`endif
   );

   modport slave (
      input start, input in_valid, input in_data,
      output in_ready, output output_valid, output feature_idx, output feature_row,
      output data_out, output busy, output frame_done, output dbg_state
`ifdef POOL_SENDER_CHECK_EN
      , output err
`endif
   );

endinterface

// File: rtl/pooling_row_buffer.sv
// Two-entry tagged row FIFO; the head entry is the row being serialised.
module pooling_row_buffer
   import pooling_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push_i,
   input  row_tag_t push_data_i,
   input  logic     pop_i,
   output row_tag_t head_o,
   output logic     full_o,
   output logic     empty_o
);

   row_tag_t   entry_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic [1:0] count_d;

   always_comb begin
      count_d = count_q;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         entry_q[0] <= '0;
         entry_q[1] <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         if (push_i) begin
            entry_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q          <= ~wr_ptr_q;
         end
         if (pop_i) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_d;
      end
   end

   assign head_o  = entry_q[rd_ptr_q];
   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/pooling_row_sender.sv
// Frame sequencer and row serialiser feeding pooling_layer_top.
// Optional POOL_SENDER_CHECK_EN adds a sticky protocol error flag on bus.err.
module pooling_row_sender
   import pooling_pkg::*;
(
   input logic                 clk,
   input logic                 rst_n,
   pooling_row_sender_if.slave bus
);

   state_e                   state_q, state_d;
   logic [CNT_WIDTH-1:0]     accepted_q, accepted_d;
   logic [ROW_WIDTH-1:0]     row_cnt_q, row_cnt_d;
   logic [FEATURE_WIDTH-1:0] feat_cnt_q, feat_cnt_d;
   logic [BEAT_WIDTH-1:0]    beat_q, beat_d;
   logic                     frame_done_q, frame_done_d;
   logic [ROW_BITS-1:0]      last_data_q;
   logic [FEATURE_WIDTH-1:0] last_feat_q;
   logic [ROW_WIDTH-1:0]     last_row_q;

   row_tag_t head;
   row_tag_t push_tag;
   logic     buf_full, buf_empty;
   logic     in_ready_w, accept, beat_valid, last_beat;

   assign in_ready_w = (state_q == RUN) && !buf_full && (accepted_q < CNT_WIDTH'(FRAME_ROWS));
   assign accept     = bus.in_valid && in_ready_w;
   assign beat_valid = !buf_empty;
   assign last_beat  = beat_valid && (beat_q == BEAT_WIDTH'(OUTPUT_SIZE - 1));
   assign push_tag   = '{feature: feat_cnt_q, row: row_cnt_q, data: bus.in_data};

   // Popping on the last beat while pushing lets the next row start with no bubble.
   pooling_row_buffer u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (accept),
      .push_data_i(push_tag),
      .pop_i      (last_beat),
      .head_o     (head),
      .full_o     (buf_full),
      .empty_o    (buf_empty)
   );

   always_comb begin
      state_d      = state_q;
      accepted_d   = accepted_q;
      row_cnt_d    = row_cnt_q;
      feat_cnt_d   = feat_cnt_q;
      beat_d       = beat_q;
      frame_done_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d    = RUN;
               accepted_d = '0;
               row_cnt_d  = '0;
               feat_cnt_d = '0;
            end
         end
         RUN: begin
            if (accept && (accepted_q == CNT_WIDTH'(FRAME_ROWS - 1))) state_d = FLUSH;
         end
         FLUSH: begin
            // Last beat of the only remaining entry ends the frame.
            if (last_beat && !buf_full) begin
               state_d      = IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         accepted_d = accepted_q + 1'b1;
         if (row_cnt_q == ROW_WIDTH'(INPUT_SIZE - 1)) begin
            row_cnt_d  = '0;
            feat_cnt_d = feat_cnt_q + 1'b1;
         end else begin
            row_cnt_d = row_cnt_q + 1'b1;
         end
      end

      if (last_beat)       beat_d = '0;
      else if (beat_valid) beat_d = beat_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         accepted_q   <= '0;
         row_cnt_q    <= '0;
         feat_cnt_q   <= '0;
         beat_q       <= '0;
         frame_done_q <= 1'b0;
         last_data_q  <= '0;
         last_feat_q  <= '0;
         last_row_q   <= '0;
      end else begin
         state_q      <= state_d;
         accepted_q   <= accepted_d;
         row_cnt_q    <= row_cnt_d;
         feat_cnt_q   <= feat_cnt_d;
         beat_q       <= beat_d;
         frame_done_q <= frame_done_d;
         if (beat_valid) begin
            last_data_q <= window_shift(head.data, beat_q);
            last_feat_q <= head.feature;
            last_row_q  <= head.row;
         end
      end
   end

   assign bus.in_ready     = in_ready_w;
   assign bus.output_valid = beat_valid;
   assign bus.data_out     = beat_valid ? window_shift(head.data, beat_q) : last_data_q;
   assign bus.feature_idx  = beat_valid ? head.feature : last_feat_q;
   assign bus.feature_row  = beat_valid ? head.row : last_row_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.frame_done   = frame_done_q;
   assign bus.dbg_state    = state_q;

`ifdef POOL_SENDER_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q | (bus.in_valid & (state_q != RUN)) | (bus.start & (state_q != IDLE));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_pooling_row_sender.sv
// Self-checking bench for pooling_row_sender: random rows against a word-level
// reference model of the beat stream, plus protocol and reset scenarios.
module tb_pooling_row_sender;
   import pooling_pkg::*;

   localparam int TAG_W       = FEATURE_WIDTH + ROW_WIDTH + ROW_BITS;
   localparam int ROW_BUDGET  = 20;
   localparam int DONE_BUDGET = 400;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   pooling_row_sender_if bus ();

   pooling_row_sender dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: records every beat and frame_done pulse at the falling edge.
   logic [TAG_W-1:0]    obs_q[$];
   int                  obs_t[$];
   int                  fd_t[$];
   logic                fd_busy[$];
   logic [ROW_BITS-1:0] last_data = '0;
   bit                  have_last = 1'b0;
   int                  hold_bad  = 0;

   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         have_last = 1'b0;
      end else if (bus.output_valid === 1'b1) begin
         obs_q.push_back({bus.feature_idx, bus.feature_row, bus.data_out});
         obs_t.push_back(cyc);
         last_data = bus.data_out;
         have_last = 1'b1;
      end else if (have_last && (bus.data_out !== last_data)) begin
         hold_bad++;
      end
      if (bus.frame_done === 1'b1) begin
         fd_t.push_back(cyc);
         fd_busy.push_back(bus.busy);
      end
   end

   // Reference model: rows in accept order, tags feature-major.
   logic [ROW_BITS-1:0] row_q[$];
   int                  acc_t[$];
   logic [TAG_W-1:0]    exp_q[$];
   int                  pat_ob = 0;

   function automatic logic [ROW_BITS-1:0] ref_beat(input logic [ROW_BITS-1:0] row, input int k);
      logic [DATA_WIDTH-1:0] w [INPUT_SIZE];
      logic [ROW_BITS-1:0]   r;
      r = '0;
      for (int j = 0; j < INPUT_SIZE; j++) w[j] = row[(INPUT_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH];
      for (int j = 0; j < INPUT_SIZE; j++)
         if (j + k*KERNEL_SIZE < INPUT_SIZE) r[(INPUT_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH] = w[j + k*KERNEL_SIZE];
      return r;
   endfunction

   task automatic build_expected();
      exp_q.delete();
      foreach (row_q[i])
         for (int k = 0; k < OUTPUT_SIZE; k++)
            exp_q.push_back({FEATURE_WIDTH'(i / INPUT_SIZE), ROW_WIDTH'(i % INPUT_SIZE), ref_beat(row_q[i], k)});
   endtask

   task automatic clear_model();
      row_q.delete();
      acc_t.delete();
      exp_q.delete();
   endtask

   // Drivers
   function automatic logic [ROW_BITS-1:0] rand_row();
      logic [ROW_BITS-1:0] d;
      for (int j = 0; j < INPUT_SIZE; j++) d[j*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
      return d;
   endfunction

   task automatic apply_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic drive_rows(input int n, input int gap, input int start_at, input bit fixed_first,
                             output int n_acc);
      n_acc = 0;
      for (int i = 0; i < n; i++) begin
         logic [ROW_BITS-1:0] d;
         int tries;
         bit got;
         d = rand_row();
         if (fixed_first && i == 0)
            for (int j = 0; j < INPUT_SIZE; j++) d[(INPUT_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(j + 1);
         bus.in_valid = 1'b1;
         bus.in_data  = d;
         got   = 1'b0;
         tries = 0;
         while (!got && tries < ROW_BUDGET) begin
            if (i == start_at && tries == 0) bus.start = 1'b1;
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
               got = 1'b1;
               row_q.push_back(d);
               acc_t.push_back(cyc);
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            tries++;
         end
         bus.in_valid = 1'b0;
         if (!got) break;
         n_acc++;
         repeat (gap) begin @(posedge clk); #1; end
      end
   endtask

   task automatic wait_done(input int fb);
      int n;
      n = 0;
      while (fd_t.size() == fb && n < DONE_BUDGET) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
   endtask

   // Tests
   task automatic test_reset();
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b expected 0", bus.in_ready); end
      checks++; if (bus.output_valid !== 1'b0) begin errors++; $display("FAIL reset_output_valid got %b expected 0", bus.output_valid); end
      checks++; if (bus.feature_idx !== '0) begin errors++; $display("FAIL reset_feature_idx got %0d expected 0", bus.feature_idx); end
      checks++; if (bus.feature_row !== '0) begin errors++; $display("FAIL reset_feature_row got %0d expected 0", bus.feature_row); end
      checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL reset_data_out got %h expected 0", bus.data_out); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
      checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b expected 0", bus.frame_done); end
      checks++; if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d expected IDLE", bus.dbg_state); end
`ifdef POOL_SENDER_CHECK_EN
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", bus.err); end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_idle_valid();
      int ob;
      ob = obs_q.size();
      bus.in_valid = 1'b1;
      bus.in_data  = rand_row();
      repeat (6) begin
         @(negedge clk);
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got %b expected 0", bus.in_ready); end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (obs_q.size() != ob) begin errors++; $display("FAIL idle_beats got %0d expected 0", obs_q.size() - ob); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b expected 0", bus.busy); end
`ifdef POOL_SENDER_CHECK_EN
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL idle_err got %b expected 1", bus.err); end
      apply_reset();
      @(negedge clk);
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL idle_err_clear got %b expected 0", bus.err); end
      @(posedge clk); #1;
`endif
   endtask

   task automatic test_full_frame();
      int ob, fb, n_acc, last;
      clear_model();
      ob = obs_q.size(); fb = fd_t.size(); pat_ob = ob;
      pulse_start();
      drive_rows(FRAME_ROWS, 0, -1, 1'b1, n_acc);
      wait_done(fb);
      build_expected();
      checks++; if (n_acc != FRAME_ROWS) begin errors++; $display("FAIL full_rows got %0d expected %0d", n_acc, FRAME_ROWS); end
      checks++; if (obs_q.size() - ob != exp_q.size()) begin errors++; $display("FAIL full_beat_count got %0d expected %0d", obs_q.size() - ob, exp_q.size()); end
      foreach (exp_q[i]) if (ob + i < obs_q.size()) begin
         checks++; if (obs_q[ob+i] !== exp_q[i]) begin errors++; $display("FAIL full_beat[%0d] got %h expected %h", i, obs_q[ob+i], exp_q[i]); end
         checks++; if (obs_t[ob+i] != acc_t[0] + 1 + i) begin errors++; $display("FAIL full_beat_cycle[%0d] got %0d expected %0d", i, obs_t[ob+i], acc_t[0] + 1 + i); end
      end
      checks++; if (fd_t.size() - fb != 1) begin errors++; $display("FAIL full_done_count got %0d expected 1", fd_t.size() - fb); end
      if (fd_t.size() > fb && obs_q.size() > ob) begin
         last = obs_t[obs_t.size()-1];
         checks++; if (fd_t[fb] != last + 1) begin errors++; $display("FAIL full_done_cycle got %0d expected %0d", fd_t[fb], last + 1); end
         checks++; if (fd_busy[fb] !== 1'b0) begin errors++; $display("FAIL full_done_busy got %b expected 0", fd_busy[fb]); end
      end
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL full_idle_busy got %b expected 0", bus.busy); end
      checks++; if (bus.output_valid !== 1'b0) begin errors++; $display("FAIL full_idle_valid got %b expected 0", bus.output_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_row_pattern();
      logic [ROW_BITS-1:0] d;
      logic [DATA_WIDTH-1:0] exp_w;
      for (int k = 0; k < OUTPUT_SIZE; k++) begin
         checks++;
         if (pat_ob + k >= obs_q.size()) begin
            errors++; $display("FAIL pattern_beat%0d missing got none expected beat", k);
         end else begin
            d = obs_q[pat_ob+k][ROW_BITS-1:0];
            for (int j = 0; j < INPUT_SIZE; j++) begin
               exp_w = (j + k*KERNEL_SIZE < INPUT_SIZE) ? DATA_WIDTH'(j + k*KERNEL_SIZE + 1) : '0;
               checks++;
               if (d[(INPUT_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH] !== exp_w) begin
                  errors++; $display("FAIL pattern_beat%0d_word%0d got %0d expected %0d", k, j,
                                     d[(INPUT_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH], exp_w);
               end
            end
         end
      end
   endtask

   task automatic test_gaps();
      int ob, fb, hb, n_acc;
      clear_model();
      ob = obs_q.size(); fb = fd_t.size(); hb = hold_bad;
      pulse_start();
      drive_rows(FRAME_ROWS, 5, -1, 1'b0, n_acc);
      wait_done(fb);
      build_expected();
      checks++; if (n_acc != FRAME_ROWS) begin errors++; $display("FAIL gap_rows got %0d expected %0d", n_acc, FRAME_ROWS); end
      checks++; if (obs_q.size() - ob != exp_q.size()) begin errors++; $display("FAIL gap_beat_count got %0d expected %0d", obs_q.size() - ob, exp_q.size()); end
      foreach (exp_q[i]) if (ob + i < obs_q.size()) begin
         checks++; if (obs_q[ob+i] !== exp_q[i]) begin errors++; $display("FAIL gap_beat[%0d] got %h expected %h", i, obs_q[ob+i], exp_q[i]); end
         checks++;
         if (obs_t[ob+i] != acc_t[i / OUTPUT_SIZE] + 1 + (i % OUTPUT_SIZE)) begin
            errors++; $display("FAIL gap_beat_cycle[%0d] got %0d expected %0d", i, obs_t[ob+i], acc_t[i / OUTPUT_SIZE] + 1 + (i % OUTPUT_SIZE));
         end
      end
      checks++; if (hold_bad != hb) begin errors++; $display("FAIL gap_data_hold got %0d changes expected 0", hold_bad - hb); end
      checks++; if (fd_t.size() - fb != 1) begin errors++; $display("FAIL gap_done_count got %0d expected 1", fd_t.size() - fb); end
   endtask

   task automatic test_start_in_run();
      int ob, fb, n_acc;
      clear_model();
      ob = obs_q.size(); fb = fd_t.size();
      pulse_start();
      drive_rows(FRAME_ROWS + 4, 0, 5, 1'b0, n_acc);
      wait_done(fb);
      build_expected();
      checks++; if (n_acc != FRAME_ROWS) begin errors++; $display("FAIL restart_rows got %0d expected %0d", n_acc, FRAME_ROWS); end
      checks++; if (obs_q.size() - ob != exp_q.size()) begin errors++; $display("FAIL restart_beat_count got %0d expected %0d", obs_q.size() - ob, exp_q.size()); end
      foreach (exp_q[i]) if (ob + i < obs_q.size()) begin
         checks++; if (obs_q[ob+i] !== exp_q[i]) begin errors++; $display("FAIL restart_beat[%0d] got %h expected %h", i, obs_q[ob+i], exp_q[i]); end
      end
      checks++; if (fd_t.size() - fb != 1) begin errors++; $display("FAIL restart_done_count got %0d expected 1", fd_t.size() - fb); end
`ifdef POOL_SENDER_CHECK_EN
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL restart_err got %b expected 1", bus.err); end
`endif
      apply_reset();
   endtask

   task automatic test_mid_reset();
      int ob, fb, n_acc;
      clear_model();
      pulse_start();
      drive_rows(10, 0, -1, 1'b0, n_acc);
      checks++; if (n_acc != 10) begin errors++; $display("FAIL midrst_rows got %0d expected 10", n_acc); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      ob = obs_q.size();
      @(negedge clk);
      checks++; if (bus.output_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b expected 0", bus.output_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", bus.busy); end
      checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL midrst_data got %h expected 0", bus.data_out); end
      repeat (8) @(posedge clk);
      #1;
      checks++; if (obs_q.size() != ob) begin errors++; $display("FAIL midrst_stray_beats got %0d expected 0", obs_q.size() - ob); end

      clear_model();
      ob = obs_q.size(); fb = fd_t.size();
      pulse_start();
      drive_rows(FRAME_ROWS, 0, -1, 1'b0, n_acc);
      wait_done(fb);
      build_expected();
      checks++; if (obs_q.size() - ob != exp_q.size()) begin errors++; $display("FAIL clean_beat_count got %0d expected %0d", obs_q.size() - ob, exp_q.size()); end
      foreach (exp_q[i]) if (ob + i < obs_q.size()) begin
         checks++; if (obs_q[ob+i] !== exp_q[i]) begin errors++; $display("FAIL clean_beat[%0d] got %h expected %h", i, obs_q[ob+i], exp_q[i]); end
      end
      checks++; if (fd_t.size() - fb != 1) begin errors++; $display("FAIL clean_done_count got %0d expected 1", fd_t.size() - fb); end
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      test_reset();
      test_idle_valid();
      test_full_frame();
      test_row_pattern();
      test_gaps();
      test_start_in_run();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
